uart_periph_interface: RTL and testbench
========================================

Name: uart_periph_interface

Overview:
- Memory-mapped UART peripheral (8N1) on the processor data bus.
- Control register sits at 0x2020, data register at 0x2024.
- Both registers are presented continuously to the read-side bus driver: ctrl_o feeds the UART-control input, data_o feeds the UART-data input.
- Write strobes come from the write-side address decoder.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer, truncated), clocks per bit. Minimum 4.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- we_ctrl_i  in  1  write strobe, control register (0x2020).
- we_data_i  in  1  write strobe, data register (0x2024).
- wd_i  in  32  write data from processor.
- rx_i  in  1  serial input, asynchronous, idle high.
- tx_o  out  1  serial output, idle high.
- ctrl_o  out  32  control register read value.
- data_o  out  32  data register read value.

Behaviour:
- Reset: tx_o=1, ctrl_o=0, data_o=0, TX latch=0, both FSMs IDLE, counters 0. Reset mid-frame aborts it; tx_o=1 from the next edge.
- ctrl_o layout: {28'b0, LOOP, FERR, NEW_RX, SEND}. data_o = {24'b0, rx_byte}.
- Register writes:
  - we_data_i loads tx_byte <= wd_i[7:0]. tx_byte is not readable.
  - SEND: write 1 sets it; write 0 is ignored. Hardware clears it.
  - NEW_RX, FERR: write 0 clears; write 1 ignored.
- Write collisions: hardware set of NEW_RX/FERR in the same cycle as a software clear → the set wins. Hardware clear of SEND in the same cycle as a software write of 1 → SEND stays 1 and a new frame starts.
- TX FSM (IDLE → START → DATA → STOP → IDLE):
  - IDLE with SEND=1: copy tx_byte into the shift register, go to START. tx_o=0 from the edge after SEND is seen.
  - Each state lasts CLKS_PER_BIT cycles. DATA sends 8 bits LSB first. STOP drives 1.
  - At the end of STOP: SEND cleared, FSM returns to IDLE.
  - Frame = 10*CLKS_PER_BIT cycles. A we_data_i during a frame does not alter the frame in flight.
- RX path:
  - rx_i passes through a 2-flop synchronizer (2 cycles latency) before use.
  - RX FSM (IDLE → START → DATA → STOP → IDLE). IDLE waits for synced rx=0.
  - START re-samples at CLKS_PER_BIT/2. If the sample is 1, it is a glitch: return to IDLE, no flag change.
  - DATA samples 8 bits at mid-bit, every CLKS_PER_BIT cycles, LSB first.
  - STOP mid-bit sample = 1: rx_byte <= shifted byte, NEW_RX <= 1.
  - STOP mid-bit sample = 0: rx_byte unchanged, FERR <= 1.
  - After STOP the FSM returns to IDLE immediately; no wait for a full stop bit.
  - A new byte overwrites rx_byte even if NEW_RX is still 1. No overrun flag.
- TX and RX run independently and may be active simultaneously.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - ctrl bit3 LOOP is read/write via we_ctrl_i (wd_i[3]).
  - LOOP=1: RX synchronizer input = internal TX serial value; rx_i ignored; tx_o held at 1.
  - LOOP=0: normal operation.
- Undefined: bit3 reads 0, writes to it are ignored, no loopback mux is synthesized.

Test Plan (CLK_HZ=1600, BAUD=100 → CLKS_PER_BIT=16):
- Transmit: write data 0x55, then ctrl 0x1 → tx_o sequence 0,1,0,1,0,1,0,1,0,1, each level 16 cycles. ctrl_o[0] falls to 0 exactly 160 cycles after the start bit begins; tx_o idles at 1 afterwards.
- Receive: drive an rx_i frame for 0xA3, 16 cycles/bit → data_o=0x000000A3 and ctrl_o=0x2 after the mid-stop sample. Then write ctrl 0x0 → ctrl_o=0x0, data_o still 0xA3.
- Framing and glitch: frame 0x3C with stop bit 0 → ctrl_o[2]=1, data_o unchanged. A 3-cycle low pulse on idle rx_i → no flag change, FSM back in IDLE.
- Collision: we_ctrl_i with wd_i=0 in the same cycle NEW_RX is set by a completing frame → ctrl_o[1]=1 afterwards.
- Reset mid-frame: assert rst_i during TX bit 4 and RX bit 5 → next cycle tx_o=1, ctrl_o=0, data_o=0. A fresh send after reset produces a complete, correct frame.
- With UART_LOOPBACK_EN: write ctrl 0x8, data 0xC7, ctrl 0x9 → tx_o stays 1; ctrl_o becomes 0xA (LOOP=1, NEW_RX=1, SEND=0) and data_o=0xC7 once the loopback frame completes. Without the macro, writing ctrl 0x8 → ctrl_o[3]=0.

Source files
------------

// File: rtl/uart_periph_interface.sv
// Memory-mapped 8N1 UART: control register at 0x2020, data register at 0x2024.
// Optional internal TX->RX loopback (ctrl bit3) when UART_LOOPBACK_EN is defined.
//   state   | meaning
//   S_IDLE  | line idle, waiting for SEND (tx) or a low level (rx)
//   S_START | start bit (rx: half-bit re-sample rejects glitches)
//   S_DATA  | 8 data bits, LSB first
//   S_STOP  | stop bit
module uart_periph_interface #(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_ctrl_i,
  input  logic        we_data_i,
  input  logic [31:0] wd_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic [31:0] ctrl_o,
  output logic [31:0] data_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t r_tx_state, w_tx_state_nxt, r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt, r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0] r_tx_idx, w_tx_idx_nxt, r_rx_idx, w_rx_idx_nxt;
  logic [7:0] r_tx_shift, w_tx_shift_nxt, r_rx_shift, w_rx_shift_nxt;
  logic [7:0] r_tx_byte, r_rx_byte;
  logic r_send, r_new_rx, r_ferr;
  logic r_rx_meta, r_rx_sync;
  logic w_tx_done, w_tx_ser, w_rx_set_new, w_rx_set_ferr, w_rx_src;
  logic w_unused_wd;

  assign w_unused_wd = &{1'b0, wd_i[31:8]};

`ifdef UART_LOOPBACK_EN
  logic r_loop;
  assign w_rx_src = r_loop ? w_tx_ser : rx_i;
  assign tx_o     = r_loop ? 1'b1 : w_tx_ser;
  assign ctrl_o   = {28'b0, r_loop, r_ferr, r_new_rx, r_send};
`else
  assign w_rx_src = rx_i;
  assign tx_o     = w_tx_ser;
  assign ctrl_o   = {28'b0, 1'b0, r_ferr, r_new_rx, r_send};
`endif
  assign data_o = {24'b0, r_rx_byte};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_tx_byte  <= '0;
      r_rx_byte  <= '0;
      r_send     <= 1'b0;
      r_new_rx   <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_LOOPBACK_EN
      r_loop     <= 1'b0;
`endif
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_meta  <= w_rx_src;
      r_rx_sync  <= r_rx_meta;
      if (we_data_i) r_tx_byte <= wd_i[7:0];
      if (w_rx_set_new) r_rx_byte <= r_rx_shift;
      // a software SEND=1 outranks the end-of-frame clear, so back-to-back frames work
      if (we_ctrl_i && wd_i[0]) r_send <= 1'b1;
      else if (w_tx_done)       r_send <= 1'b0;
      if (w_rx_set_new)                r_new_rx <= 1'b1;
      else if (we_ctrl_i && !wd_i[1])  r_new_rx <= 1'b0;
      if (w_rx_set_ferr)               r_ferr <= 1'b1;
      else if (we_ctrl_i && !wd_i[2])  r_ferr <= 1'b0;
`ifdef UART_LOOPBACK_EN
      if (we_ctrl_i) r_loop <= wd_i[3];
`endif
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_done      = 1'b0;
    w_tx_ser       = 1'b1;
    case (r_tx_state)
      S_IDLE: if (r_send) begin
        w_tx_state_nxt = S_START;
        w_tx_cnt_nxt   = BIT_LAST;
        w_tx_idx_nxt   = '0;
        w_tx_shift_nxt = r_tx_byte;
      end
      S_START: begin
        w_tx_ser = 1'b0;
        if (r_tx_cnt == '0) begin
          w_tx_state_nxt = S_DATA;
          w_tx_cnt_nxt   = BIT_LAST;
        end else w_tx_cnt_nxt = r_tx_cnt - 1'b1;
      end
      S_DATA: begin
        w_tx_ser = r_tx_shift[0];
        if (r_tx_cnt == '0) begin
          w_tx_cnt_nxt   = BIT_LAST;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_idx_nxt   = r_tx_idx + 1'b1;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = S_STOP;
        end else w_tx_cnt_nxt = r_tx_cnt - 1'b1;
      end
      S_STOP: begin
        if (r_tx_cnt == '0) begin
          w_tx_state_nxt = S_IDLE;
          w_tx_done      = 1'b1;
        end else w_tx_cnt_nxt = r_tx_cnt - 1'b1;
      end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_set_new   = 1'b0;
    w_rx_set_ferr  = 1'b0;
    case (r_rx_state)
      S_IDLE: if (!r_rx_sync) begin
        w_rx_state_nxt = S_START;
        w_rx_cnt_nxt   = HALF_LAST;
        w_rx_idx_nxt   = '0;
      end
      S_START: begin
        if (r_rx_cnt == '0) begin
          w_rx_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
          w_rx_cnt_nxt   = BIT_LAST;
        end else w_rx_cnt_nxt = r_rx_cnt - 1'b1;
      end
      S_DATA: begin
        if (r_rx_cnt == '0) begin
          w_rx_cnt_nxt   = BIT_LAST;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_idx_nxt   = r_rx_idx + 1'b1;
          if (r_rx_idx == 3'd7) w_rx_state_nxt = S_STOP;
        end else w_rx_cnt_nxt = r_rx_cnt - 1'b1;
      end
      S_STOP: begin
        // decide on the mid-stop sample and go idle right away
        if (r_rx_cnt == '0) begin
          w_rx_state_nxt = S_IDLE;
          w_rx_set_new   = r_rx_sync;
          w_rx_set_ferr  = !r_rx_sync;
        end else w_rx_cnt_nxt = r_rx_cnt - 1'b1;
      end
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_periph_interface.sv
// Directed bench for uart_periph_interface at 16 clocks per bit.
// Define UART_LOOPBACK_EN for both files to exercise the loopback path.
module tb_uart_periph_interface;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_ctrl = 1'b0;
  logic        we_data = 1'b0;
  logic [31:0] wd = '0;
  logic        rx = 1'b1;
  logic        tx;
  logic [31:0] ctrl;
  logic [31:0] data;

  int checks = 0;
  int errors = 0;

  uart_periph_interface #(.CLK_HZ(1600), .BAUD(100)) dut (
    .clk_i(clk), .rst_i(rst), .we_ctrl_i(we_ctrl), .we_data_i(we_data),
    .wd_i(wd), .rx_i(rx), .tx_o(tx), .ctrl_o(ctrl), .data_o(data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we_ctrl;
    logic        we_data;
    logic [31:0] wd;
    logic [31:0] exp_ctrl;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // write data then SEND, then check every cycle of the 160-cycle frame
  task automatic send_and_check(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    we_data = 1'b1; wd = {24'b0, b}; tick();
    we_data = 1'b0; we_ctrl = 1'b1; wd = 32'h1; tick();
    we_ctrl = 1'b0; wd = '0;
    chk("send_set", 32'(ctrl[0]), 32'h1);
    chk("tx_before_start", 32'(tx), 32'h1);
    for (int i = 0; i < 160; i++) begin
      if (i == 40) begin we_data = 1'b1; wd = 32'hFF; end
      else we_data = 1'b0;
      tick();
      chk($sformatf("tx_bit_c%0d", i), 32'(tx), 32'(frame[i/16]));
      if (i == 159) chk("send_held_to_end", 32'(ctrl[0]), 32'h1);
    end
    we_data = 1'b0; wd = '0;
    tick();
    chk("send_cleared_at_160", 32'(ctrl[0]), 32'h0);
    chk("tx_idle_after", 32'(tx), 32'h1);
  endtask

  // rx_i frame, 16 cycles/bit; clr_idx >= 0 puts a ctrl write of 0 in that cycle
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int clr_idx);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int n = 0; n < 160; n++) begin
      rx = bits[n/16];
      if (n == clr_idx) begin we_ctrl = 1'b1; wd = '0; end
      else we_ctrl = 1'b0;
      tick();
    end
    rx = 1'b1; we_ctrl = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [9:0] rbits;
    int guard;
    logic saw_low;

    vecs[0] = '{1'b0, 1'b0, 32'h0,          32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFF6,  32'h0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h1234_5678,  32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h1,          32'h1, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,          32'h1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0,          32'h1, 32'h0};
    vecs[6] = '{1'b0, 1'b1, 32'hAB,         32'h1, 32'h0};

    idle(3);
    rst = 1'b0;
    chk("rst_tx", 32'(tx), 32'h1);
    chk("rst_ctrl", ctrl, 32'h0);
    chk("rst_data", data, 32'h0);

    for (int i = 0; i < 7; i++) begin
      we_ctrl = vecs[i].we_ctrl; we_data = vecs[i].we_data; wd = vecs[i].wd;
      tick();
      we_ctrl = 1'b0; we_data = 1'b0; wd = '0;
      chk($sformatf("vec%0d_ctrl", i), ctrl, vecs[i].exp_ctrl);
      chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
    end
    guard = 0;
    while (ctrl[0] && guard < 300) begin tick(); guard++; end
    chk("vec_send_completes", 32'(ctrl[0]), 32'h0);
    idle(5);

    send_and_check(8'h55);

    rx_frame(8'hA3, 1'b1, -1);
    idle(20);
    chk("rx_a3_data", data, 32'hA3);
    chk("rx_a3_ctrl", ctrl, 32'h2);
    we_ctrl = 1'b1; wd = '0; tick(); we_ctrl = 1'b0;
    chk("clr_ctrl", ctrl, 32'h0);
    chk("clr_data_kept", data, 32'hA3);

    rx_frame(8'h3C, 1'b0, -1);
    idle(40);
    chk("ferr_ctrl", ctrl, 32'h4);
    chk("ferr_data_kept", data, 32'hA3);

    rx = 1'b0; idle(3); rx = 1'b1;
    idle(40);
    chk("glitch_ctrl", ctrl, 32'h4);
    chk("glitch_data", data, 32'hA3);

    rx_frame(8'h5A, 1'b1, 154);
    idle(20);
    chk("collision_ctrl", ctrl, 32'h2);
    chk("collision_data", data, 32'h5A);

    we_data = 1'b1; wd = 32'h69; tick(); we_data = 1'b0;
    rbits = {1'b1, 8'h3C, 1'b0};
    for (int n = 0; n <= 96; n++) begin
      rx = rbits[n/16];
      we_ctrl = (n == 0); wd = (n == 0) ? 32'h1 : 32'h0;
      if (n == 96) begin
        chk("pre_rst_tx_bit4", 32'(tx), 32'h0);
        rst = 1'b1;
      end
      tick();
    end
    we_ctrl = 1'b0; wd = '0; rx = 1'b1;
    chk("midrst_tx", 32'(tx), 32'h1);
    chk("midrst_ctrl", ctrl, 32'h0);
    chk("midrst_data", data, 32'h0);
    rst = 1'b0;
    idle(5);
    send_and_check(8'hB4);
    chk("post_rst_ctrl", ctrl, 32'h0);
    chk("post_rst_data", data, 32'h0);

`ifdef UART_LOOPBACK_EN
    we_ctrl = 1'b1; wd = 32'h8; tick(); we_ctrl = 1'b0;
    chk("loop_set", ctrl, 32'h8);
    we_data = 1'b1; wd = 32'hC7; tick(); we_data = 1'b0;
    we_ctrl = 1'b1; wd = 32'h9; tick(); we_ctrl = 1'b0; wd = '0;
    saw_low = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (!tx) saw_low = 1'b1;
    end
    chk("loop_tx_held", 32'(saw_low), 32'h0);
    chk("loop_ctrl", ctrl, 32'hA);
    chk("loop_data", data, 32'hC7);
`else
    saw_low = 1'b0;
    we_ctrl = 1'b1; wd = 32'h8; tick(); we_ctrl = 1'b0; wd = '0;
    chk("noloop_bit3", ctrl, 32'h0);
    chk("noloop_tx", 32'(tx | saw_low), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
